// File: rtl/vga_pkg.sv
// Shared character-code constants for the video text path, plus the typewriter FSM state type.
package vga_pkg;

  localparam logic [6:0] SPACE = 7'h20;
  localparam logic [6:0] C_A = 7'h41, C_B = 7'h42, C_C = 7'h43, C_D = 7'h44, C_E = 7'h45,
                         C_F = 7'h46, C_G = 7'h47, C_H = 7'h48, C_I = 7'h49, C_J = 7'h4A,
                         C_K = 7'h4B, C_L = 7'h4C, C_M = 7'h4D, C_N = 7'h4E, C_O = 7'h4F,
                         C_P = 7'h50, C_Q = 7'h51, C_R = 7'h52, C_S = 7'h53, C_T = 7'h54,
                         C_U = 7'h55, C_V = 7'h56, C_W = 7'h57, C_X = 7'h58, C_Y = 7'h59,
                         C_Z = 7'h5A;
  localparam logic [6:0] C_1    = 7'h31;
  localparam logic [6:0] NKL    = 7'h01;
  localparam logic [6:0] NKR    = 7'h02;
  localparam logic [6:0] CURSOR = 7'h7F;

  typedef enum logic [1:0] {IDLE, REVEAL, DONE} game_txt_state_t;

endpackage

// File: rtl/game_text_rom.sv
// Combinational page text ROM: (page, {row, col}) -> character code, SPACE where nothing is placed.
// Row and column address widths up to 8 bits each are supported.
module game_text_rom
  import vga_pkg::*;
#(
  parameter int COL_W     = 4,
  parameter int ROW_W     = 4,
  parameter int NUM_PAGES = 4,
  localparam int PAGE_W   = $clog2(NUM_PAGES)
) (
  input  logic [PAGE_W-1:0]      page,
  input  logic [ROW_W+COL_W-1:0] char_xy,
  output logic [6:0]             code
);

  // Key layout {page, row, col}, one byte each, so the table reads as coordinates.
  logic [23:0] key;
  assign key = {8'(page), 8'(char_xy[ROW_W+COL_W-1:COL_W]), 8'(char_xy[COL_W-1:0])};

  always_comb begin
    // NOTE: default first, so every path assigns code and no latch is inferred.
    code = SPACE;
    case (key)
      24'h00_07_06: code = C_S;
      24'h00_07_07: code = C_T;
      24'h00_07_08: code = C_A;
      24'h00_07_09: code = C_R;
      24'h00_07_0A: code = C_T;
      24'h00_0F_0F: code = NKR;
      24'h01_00_00: code = C_P;
      24'h01_00_01: code = C_L;
      24'h01_00_02: code = C_A;
      24'h01_00_03: code = C_Y;
      24'h01_00_04: code = C_E;
      24'h01_00_05: code = C_R;
      24'h01_00_07: code = C_1;
      24'h01_0F_0E: code = NKL;
      24'h01_0F_0F: code = NKR;
      24'h02_07_03: code = C_G;
      24'h02_07_04: code = C_A;
      24'h02_07_05: code = C_M;
      24'h02_07_06: code = C_E;
      24'h02_07_08: code = C_O;
      24'h02_07_09: code = C_V;
      24'h02_07_0A: code = C_E;
      24'h02_07_0B: code = C_R;
      24'h02_0F_0F: code = NKR;
      24'h03_08_05: code = C_P;
      24'h03_08_06: code = C_A;
      24'h03_08_07: code = C_U;
      24'h03_08_08: code = C_S;
      24'h03_08_09: code = C_E;
      24'h03_0F_0F: code = NKR;
      default:      code = SPACE;
    endcase
  end

endmodule

// File: rtl/game_text_typer.sv
// Multi-page text source with typewriter reveal paced by frame ticks.
// Optional blinking cursor at the reveal position: define GAME_TXT_CURSOR_EN.
module game_text_typer
  import vga_pkg::*;
#(
  parameter int COL_W      = 4,
  parameter int ROW_W      = 4,
  parameter int NUM_PAGES  = 4,
  parameter int REVEAL_DIV = 2,
  localparam int PAGE_W    = $clog2(NUM_PAGES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PAGE_W-1:0]      page_sel,
  input  logic                   page_load,
  input  logic                   frame_tick,
  input  logic                   skip,
  input  logic [ROW_W+COL_W-1:0] char_xy,
  output logic [6:0]             char_code,
  output logic                   busy,
  output logic                   reveal_done
);

  localparam int XY_W  = ROW_W + COL_W;
  localparam int DIV_W = (REVEAL_DIV > 1) ? $clog2(REVEAL_DIV) : 1;
  localparam logic [XY_W:0]    CELLS   = (XY_W+1)'(2 ** XY_W);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(REVEAL_DIV - 1);

  game_txt_state_t   state;
  logic [PAGE_W-1:0] page;
  logic [XY_W:0]     reveal_idx;
  logic [XY_W:0]     next_idx;
  logic [DIV_W-1:0]  div_cnt;
  logic [6:0]        rom_code;
  logic              cursor_here;

  assign next_idx = reveal_idx + (XY_W+1)'(1);

  game_text_rom #(
    .COL_W     (COL_W),
    .ROW_W     (ROW_W),
    .NUM_PAGES (NUM_PAGES)
  ) u_rom (
    .page    (page),
    .char_xy (char_xy),
    .code    (rom_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      page        <= '0;
      reveal_idx  <= '0;
      div_cnt     <= '0;
      busy        <= 1'b0;
      reveal_done <= 1'b0;
    end else if (page_load) begin
      state       <= REVEAL;
      page        <= page_sel;
      reveal_idx  <= '0;
      div_cnt     <= '0;
      busy        <= 1'b1;
      reveal_done <= 1'b0;
    end else if (state == REVEAL) begin
      if (skip) begin
        state       <= DONE;
        reveal_idx  <= CELLS;
        busy        <= 1'b0;
        reveal_done <= 1'b1;
      end else if (frame_tick) begin
        if (div_cnt == DIV_TOP) begin
          div_cnt    <= '0;
          reveal_idx <= next_idx;
          if (next_idx == CELLS) begin
            state       <= DONE;
            busy        <= 1'b0;
            reveal_done <= 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

`ifdef GAME_TXT_CURSOR_EN
  logic [3:0] blink_cnt;
  logic       blink;

  // Blink phase runs off every frame tick and restarts with each page.
  always_ff @(posedge clk) begin
    if (rst || page_load) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame_tick) begin
      blink_cnt <= blink_cnt + 4'd1;
      if (blink_cnt == 4'hF) blink <= ~blink;
    end
  end

  assign cursor_here = blink && ({1'b0, char_xy} == reveal_idx);
`else
  assign cursor_here = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      char_code <= SPACE;
    end else begin
      case (state)
        REVEAL: begin
          if ({1'b0, char_xy} < reveal_idx) char_code <= rom_code;
          else if (cursor_here)             char_code <= CURSOR;
          else                              char_code <= SPACE;
        end
        DONE:    char_code <= rom_code;
        default: char_code <= SPACE;
      endcase
    end
  end

endmodule

// File: doc/game_text_typer.md
# game_text_typer

Parametrised multi-page character-text source for the game screens with a "typewriter" reveal: characters of the selected page appear one cell at a time, paced by frame ticks. Sits between the game FSM (page select, frame tick, skip) and the character-rendering pipeline (char_xy in, char_code out). It replaces the single fixed-page text ROMs.

## Interface
- COL_W, 4, column address bits; COLS = 2**COL_W
- ROW_W, 4, row address bits; ROWS = 2**ROW_W
- NUM_PAGES, 4, number of text pages; PAGE_W = $clog2(NUM_PAGES)
- REVEAL_DIV, 2, frame ticks per revealed cell (>= 1)
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset
- page_sel  input  PAGE_W  page index, sampled only when page_load = 1
- page_load  input  1  one-cycle pulse: latch page_sel and restart the reveal
- frame_tick  input  1  one-cycle pulse per video frame
- skip  input  1  one-cycle pulse: reveal the whole page immediately
- char_xy  input  ROW_W+COL_W  {row, col} cell address from the renderer
- char_code  output  7  character code for char_xy, registered
- busy  output  1  reveal in progress
- reveal_done  output  1  whole page shown

## Operation
- Linear cell index = char_xy (row*COLS + col). CELLS = 2**(ROW_W+COL_W). reveal_idx is ROW_W+COL_W+1 bits wide and ranges 0..CELLS.
- States: IDLE, REVEAL, DONE.
- IDLE: all cells SPACE. page_load -> REVEAL.
- REVEAL: cell shown if index < reveal_idx, else SPACE. On frame_tick, div_cnt increments. When frame_tick arrives with div_cnt == REVEAL_DIV-1, div_cnt clears and reveal_idx increments. When that increment reaches CELLS, the state goes to DONE. skip -> DONE, reveal_idx = CELLS.
- DONE: all cells shown. The block holds this state until page_load.
- page_load in any state: latch page, reveal_idx = 0, div_cnt = 0, state = REVEAL.
- Priority for simultaneous events: rst > page_load > skip > frame_tick.
- Shown cells output the ROM code for (page, char_xy). Unshown cells output SPACE.
- busy = (state == REVEAL). reveal_done = (state == DONE). Both are registered.

## Timing
- Reset values: state IDLE, page 0, reveal_idx 0, div_cnt 0, char_code SPACE, busy 0, reveal_done 0.
- Reset applied mid-reveal forces the reset values on the next edge.
- char_code latency: 1 clk from char_xy. The value uses the reveal_idx and page registered at the sampling edge.
- Control latency: page_load, skip or the last-cell tick updates state, busy and reveal_done at edge N+1. char_code reflects the change for addresses sampled from edge N+1 on, and appears at N+2.
- A page_load during REVEAL does not wait for the current reveal to finish. frame_tick in IDLE or DONE is ignored.
- REVEAL_DIV = 1: one cell per frame_tick.

## Configuration
- GAME_TXT_CURSOR_EN defined:
  - In REVEAL, the cell at index == reveal_idx outputs CURSOR while blink = 1.
  - blink resets to 0 and toggles every 16 frame_ticks.
  - blink is cleared on page_load.
  - No cursor is shown in IDLE or DONE.
- GAME_TXT_CURSOR_EN undefined: that cell outputs SPACE, and no blink logic is built.

## Structure
- vga_pkg holds the existing character-code constants (SPACE, letters, NKL, NKR, C_1). It gains:
  - CURSOR, a character code
  - game_txt_state_t, an enum {IDLE, REVEAL, DONE}
- Sub-module game_text_rom: purely combinational (page, char_xy) -> 7-bit code case ROM, with default SPACE. It holds all page contents.
- The top level holds the FSM, the counters, the show/hide compare and the output register.

## Test plan
- Reset: assert rst for 2 clk. Required: char_code = SPACE, busy = 0, reveal_done = 0. After reset, sweep all char_xy; every cell reads SPACE.
- Reveal pacing (REVEAL_DIV = 2): page_load with page_sel = 1, then 10 frame_ticks. Required:
  - reveal_idx = 5.
  - char_xy = 8'h04 matches the golden game_text_rom output for page 1.
  - char_xy = 8'h05 reads SPACE.
  - busy = 1.
- Completion: continue ticking until 2*CELLS = 512 ticks. Required:
  - reveal_done rises exactly one clk after the 512th tick.
  - char_xy = 8'hFF shows the ROM code.
  - Further ticks change nothing.
- Skip: skip and frame_tick in the same cycle at reveal_idx = 3. Required: the next clk gives DONE and all cells shown; div_cnt has no further effect.
- Restart: page_load with page_sel = 2 mid-reveal, in the same cycle as skip. Required: REVEAL on page 2 with reveal_idx = 0, all cells SPACE, busy = 1.
- Cursor (GAME_TXT_CURSOR_EN): at reveal_idx = 5, read char_xy = 8'h05. Required: SPACE during frame ticks 0–15, then CURSOR during ticks 16–31 (ticks counted with REVEAL_DIV large enough that the index stays at 5).
